dripper_scheduler: RTL and testbench

Multi-zone drip irrigation scheduler. It gates each zone on a shared environment condition and a per-zone soil-dry flag. Only one zone valve is open at a time, granted round-robin, with minimum-on, maximum-on and cooldown timing. A tank-empty lockout overrides everything. It sits between the sensor conditioning logic and the valve drivers.

---
 rtl/dripper_scheduler_if.sv | 25 ++
 rtl/dripper_scheduler.sv | 121 ++++++++++++
 tb/tb_dripper_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dripper_scheduler_if.sv
// dripper_scheduler_if: sensor inputs and valve-drive outputs of the drip irrigation scheduler
interface dripper_scheduler_if #(
  parameter int ZONES = 4
);
  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
  logic             enable;
  logic [ZONES-1:0] earth_dry;
  logic             air_humidity;
  logic             low_temperature;
  logic             mid_water_level;
  logic             water_empty;
  logic [ZONES-1:0] dripper_valves;
  logic [ZW-1:0]    active_zone;
  logic             busy;
  logic             lockout;
  logic             timeout;
  modport master (
    output enable, earth_dry, air_humidity, low_temperature, mid_water_level, water_empty,
    input  dripper_valves, active_zone, busy, lockout, timeout
  );
  modport slave (
    input  enable, earth_dry, air_humidity, low_temperature, mid_water_level, water_empty,
    output dripper_valves, active_zone, busy, lockout, timeout
  );
endinterface

// File: rtl/dripper_scheduler.sv
// dripper_scheduler: round-robin single-valve drip scheduler with min/max-on, cooldown and tank lockout
module dripper_scheduler #(
  parameter int ZONES    = 4,
  parameter int TIMER_W  = 8,
  parameter int MIN_ON   = 10,
  parameter int MAX_ON   = 60,
  parameter int COOLDOWN = 20
) (
  input logic clock,
  input logic reset_n,
  dripper_scheduler_if.slave bus
);
  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam logic [TIMER_W-1:0] MIN_LAST  = TIMER_W'(MIN_ON - 1);
  localparam logic [TIMER_W-1:0] MAX_LAST  = TIMER_W'(MAX_ON - 1);
  localparam logic [TIMER_W-1:0] COOL_LAST = TIMER_W'(COOLDOWN - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_COOL, ST_LOCK} state_t;
  state_t state_q, state_d;
  logic [ZW-1:0] zone_q, zone_d, last_q, last_d, pick, idx;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic enable_q, air_humidity_q, low_temperature_q, mid_water_level_q, water_empty_q;
  logic [ZONES-1:0] earth_dry_q, req;
  logic env_ok, found;
  logic [ZONES-1:0] valves_q, valves_d;
  logic [ZW-1:0] active_q, active_d;
  logic busy_q, busy_d, lockout_q, lockout_d, timeout_q, timeout_d;
  assign env_ok = air_humidity_q & (low_temperature_q | ~mid_water_level_q);
  assign req = {ZONES{env_ok & enable_q}} & earth_dry_q;
  // first requester after the previous grant, wrapping, so every zone waits at most ZONES-1 grants
  always_comb begin
    found = 1'b0;
    pick = last_q;
    idx = last_q;
    for (int k = 1; k <= ZONES; k++) begin
      idx = ZW'((int'(last_q) + k) % ZONES);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    zone_d = zone_q;
    last_d = last_q;
    timer_d = timer_q + TIMER_W'(1);
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (water_empty_q) state_d = ST_LOCK;
        else if (|req) begin
          state_d = ST_OPEN;
          zone_d = pick;
          last_d = pick;
        end
      end
      ST_OPEN: begin
        if (water_empty_q) state_d = ST_LOCK;
        else if (timer_q == MAX_LAST) begin
          state_d = ST_COOL;
          timeout_d = req[zone_q];
        end else if (timer_q >= MIN_LAST && !req[zone_q]) state_d = ST_COOL;
        if (state_d != ST_OPEN) timer_d = '0;
      end
      ST_COOL: begin
        if (water_empty_q) state_d = ST_LOCK;
        else if (timer_q == COOL_LAST) state_d = ST_IDLE;
        if (state_d != ST_COOL) timer_d = '0;
      end
      default: begin
        timer_d = '0;
        if (!water_empty_q) state_d = ST_COOL;
      end
    endcase
    valves_d = (state_d == ST_OPEN) ? (ZONES'(1) << zone_d) : '0;
    active_d = (state_d == ST_OPEN) ? zone_d : '0;
    busy_d = (state_d == ST_OPEN) || (state_d == ST_COOL);
    lockout_d = (state_d == ST_LOCK);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      earth_dry_q <= '0;
      air_humidity_q <= 1'b0;
      low_temperature_q <= 1'b0;
      mid_water_level_q <= 1'b0;
      water_empty_q <= 1'b0;
      state_q <= ST_IDLE;
      zone_q <= '0;
      last_q <= ZW'(ZONES - 1);
      timer_q <= '0;
      valves_q <= '0;
      active_q <= '0;
      busy_q <= 1'b0;
      lockout_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      enable_q <= bus.enable;
      earth_dry_q <= bus.earth_dry;
      air_humidity_q <= bus.air_humidity;
      low_temperature_q <= bus.low_temperature;
      mid_water_level_q <= bus.mid_water_level;
      water_empty_q <= bus.water_empty;
      state_q <= state_d;
      zone_q <= zone_d;
      last_q <= last_d;
      timer_q <= timer_d;
      valves_q <= valves_d;
      active_q <= active_d;
      busy_q <= busy_d;
      lockout_q <= lockout_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.dripper_valves = valves_q;
  assign bus.active_zone = active_q;
  assign bus.busy = busy_q;
  assign bus.lockout = lockout_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_dripper_scheduler.sv
// tb_dripper_scheduler: directed vector table plus an async-reset sequence for dripper_scheduler
module tb_dripper_scheduler;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  dripper_scheduler_if #(.ZONES(4)) bus ();
  dripper_scheduler #(.ZONES(4), .TIMER_W(8), .MIN_ON(4), .MAX_ON(8), .COOLDOWN(3)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clock = ~clock;
  typedef struct {
    bit rst;
    bit en;
    logic [3:0] dry;
    bit ah;
    bit lt;
    bit mid;
    bit we;
    int n;
    logic [8:0] want;
  } vec_t;
  vec_t tbl[$];
  vec_t cur;
  function automatic void set_in(bit rst, bit en, logic [3:0] dry, bit ah, bit lt, bit mid, bit we);
    cur.rst = rst;
    cur.en = en;
    cur.dry = dry;
    cur.ah = ah;
    cur.lt = lt;
    cur.mid = mid;
    cur.we = we;
  endfunction
  function automatic void expect_n(int n, logic [3:0] v, logic [1:0] az, bit b, bit l, bit t);
    cur.n = n;
    cur.want = {v, az, b, l, t};
    tbl.push_back(cur);
    cur.rst = 1'b0;
  endfunction
  function automatic void idle(int n);
    expect_n(n, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic void open(int n, int z);
    expect_n(n, 4'(1 << z), 2'(z), 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic void cool(int n, bit t);
    expect_n(n, 4'b0000, 2'd0, 1'b1, 1'b0, t);
  endfunction
  function automatic void lock(int n);
    expect_n(n, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
  endfunction
  task automatic drive(bit en, logic [3:0] dry, bit ah, bit lt, bit mid, bit we);
    bus.enable = en;
    bus.earth_dry = dry;
    bus.air_humidity = ah;
    bus.low_temperature = lt;
    bus.mid_water_level = mid;
    bus.water_empty = we;
  endtask
  task automatic check(string name, logic [8:0] want);
    logic [8:0] got;
    got = {bus.dripper_valves, bus.active_zone, bus.busy, bus.lockout, bus.timeout};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got valves=%b zone=%0d busy=%b lockout=%b timeout=%b, want valves=%b zone=%0d busy=%b lockout=%b timeout=%b",
               name, got[8:5], got[4:3], got[2], got[1], got[0], want[8:5], want[4:3], want[2], want[1], want[0]);
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask
  initial begin
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    // zone 2 short watering: request dropped early, MIN_ON still honoured
    set_in(0, 1, 4'b0100, 1, 1, 0, 0); idle(1); open(3, 2);
    set_in(0, 1, 4'b0000, 1, 1, 0, 0); open(1, 2); cool(3, 0); idle(2);
    // zone 1 held dry: MAX_ON close with timeout, then reopen
    set_in(0, 1, 4'b0010, 1, 1, 0, 0); idle(1); open(8, 1); cool(1, 1); cool(2, 0); idle(1);
    open(8, 1); cool(1, 1);
    // round robin 0,1,3,0; last one drops its request on the MAX_ON edge
    set_in(1, 1, 4'b1011, 1, 1, 0, 0); idle(1); open(8, 0); cool(1, 1); cool(2, 0); idle(1);
    open(8, 1); cool(1, 1); cool(2, 0); idle(1);
    open(8, 3); cool(1, 1); cool(2, 0); idle(1); open(7, 0);
    set_in(0, 1, 4'b0000, 1, 1, 0, 0); open(1, 0); cool(3, 0); idle(1);
    // tank empty in second open cycle, then release
    set_in(1, 1, 4'b0001, 1, 1, 0, 0); idle(1); open(2, 0);
    set_in(0, 1, 4'b0001, 1, 1, 0, 1); open(1, 0); lock(3);
    set_in(0, 1, 4'b0001, 1, 1, 0, 0); lock(1); cool(3, 0); idle(1); open(2, 0);
    // environment gating, then enable drop while open
    set_in(1, 1, 4'b0001, 0, 1, 0, 0); idle(4);
    set_in(0, 1, 4'b0001, 1, 0, 1, 0); idle(4);
    set_in(0, 1, 4'b0001, 1, 0, 0, 0); idle(1); open(2, 0);
    set_in(0, 0, 4'b0001, 1, 0, 0, 0); open(2, 0); cool(3, 0); idle(2);
    #2 reset_n = 1'b0;
    #1 check("reset", 9'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].en, tbl[i].dry, tbl[i].ah, tbl[i].lt, tbl[i].mid, tbl[i].we);
      for (int c = 0; c < tbl[i].n; c++) begin
        @(posedge clock);
        #1 check($sformatf("vec%0d.%0d", i, c), tbl[i].want);
      end
    end
    do_reset();
    drive(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 check("rst_pre_open", {4'b0100, 2'd2, 3'b100});
    #2 reset_n = 1'b0;
    #1 check("rst_async_clear", 9'd0);
    bus.earth_dry = 4'b1111;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1 check("rst_idle", 9'd0);
    @(posedge clock);
    #1 check("rst_first_grant", {4'b0001, 2'd0, 3'b100});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
